full_adder_function: RTL and testbench



---
 rtl/full_adder_function.sv | 46 ++++
 tb/tb_full_adder_function.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/full_adder_function.sv
// Single-bit full adder with combinational outputs
// and a registered copy for pipelined use.
module full_adder_function (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic cout,
    output logic s,
    input  logic ck,
    input  logic rst_n,
    output logic cout_q,
    output logic s_q
);

    function automatic logic [1:0] fa(
        input logic a,
        input logic b,
        input logic c
    );
        logic sum;
        logic carry;
        sum   = a ^ b ^ c;
        carry = (a & b) | (a & c) | (b & c);
        return {carry, sum};
    endfunction

    logic [1:0] res;

    always_comb begin
        res = fa(x, y, cin);
    end

    assign cout = res[1];
    assign s    = res[0];

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            cout_q <= 1'b0;
            s_q    <= 1'b0;
        end else begin
            cout_q <= res[1];
            s_q    <= res[0];
        end
    end

endmodule

// File: tb/tb_full_adder_function.sv
// Randomized and directed checks of full_adder_function
// against an arithmetic reference model.
module tb_full_adder_function;

    logic ck;
    logic rst_n;
    logic x;
    logic y;
    logic cin;
    logic cout;
    logic s;
    logic cout_q;
    logic s_q;

    logic p_cout;
    logic p_s;
    logic p_cout_q;
    logic p_s_q;

    int checks;
    int errors;
    logic [1:0] exp_q;

    full_adder_function dut (
        .x(x),
        .y(y),
        .cin(cin),
        .cout(cout),
        .s(s),
        .ck(ck),
        .rst_n(rst_n),
        .cout_q(cout_q),
        .s_q(s_q)
    );

    // clock and reset deliberately floating on this copy
    full_adder_function comb_only (
        .x(x),
        .y(y),
        .cin(cin),
        .cout(p_cout),
        .s(p_s),
        .ck(1'bz),
        .rst_n(1'bz),
        .cout_q(p_cout_q),
        .s_q(p_s_q)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    function automatic logic [1:0] model(input logic [2:0] v);
        int total;
        total = int'(v[2]) + int'(v[1]) + int'(v[0]);
        return total[1:0];
    endfunction

    task automatic check(
        input string      tag,
        input logic [1:0] got,
        input logic [1:0] exp
    );
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] v);
        {cin, x, y} = v;
    endtask

    task automatic check_comb(input string tag);
        check(tag, {cout, s}, model({cin, x, y}));
    endtask

    initial begin
        logic [2:0] v;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(3'b011);
        #2;
        check("reset_q", {cout_q, s_q}, 2'b00);
        check_comb("reset_comb");

        @(negedge ck);
        rst_n = 1'b1;

        // exhaustive sweep, one vector per clock
        for (int i = 0; i < 8; i++) begin
            @(negedge ck);
            v = 3'(i);
            drive(v);
            #1;
            check_comb("sweep_comb");
            check("sweep_pos", {p_cout, p_s}, model(v));
            @(posedge ck);
            #1;
            check("sweep_q", {cout_q, s_q}, model(v));
        end

        @(negedge ck);
        drive(3'b000);
        #1;
        check("bound_000", {cout, s}, 2'b00);
        drive(3'b111);
        #1;
        check("bound_111", {cout, s}, 2'b11);

        // registered latency
        @(negedge ck);
        drive(3'b110);
        @(posedge ck);
        #1;
        check("lat_edge", {cout_q, s_q}, 2'b10);
        @(negedge ck);
        drive(3'b000);
        #1;
        check("lat_hold", {cout_q, s_q}, 2'b10);
        check("lat_comb", {cout, s}, 2'b00);
        @(posedge ck);
        #1;
        check("lat_next", {cout_q, s_q}, 2'b00);

        // asynchronous reset between edges
        @(negedge ck);
        drive(3'b111);
        @(posedge ck);
        #1;
        check("pre_rst", {cout_q, s_q}, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", {cout_q, s_q}, 2'b00);
        check("rst_comb", {cout, s}, 2'b11);

        // hold reset for 3 clocks, then release
        @(negedge ck);
        drive(3'b101);
        for (int i = 0; i < 3; i++) begin
            @(posedge ck);
            #1;
            check("rst_hold", {cout_q, s_q}, 2'b00);
        end
        @(negedge ck);
        rst_n = 1'b1;
        #1;
        check("rel_wait", {cout_q, s_q}, 2'b00);
        @(posedge ck);
        #1;
        check("rel_cap", {cout_q, s_q}, 2'b10);

        // randomized run with the model tracking the register
        exp_q = {cout_q, s_q};
        for (int i = 0; i < 200; i++) begin
            @(negedge ck);
            v = 3'($urandom_range(0, 7));
            drive(v);
            #1;
            check("rnd_hold", {cout_q, s_q}, exp_q);
            check_comb("rnd_comb");
            check("rnd_pos", {p_cout, p_s}, model(v));
            @(posedge ck);
            exp_q = model(v);
            #1;
            check("rnd_q", {cout_q, s_q}, exp_q);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
